// File: rtl/lua_instr_prefetch_queue.sv
//-----------------------------------------------------------------------------
// lua_instr_prefetch_queue
//
// Sequential instruction prefetcher for the Lua CPU. Reads bytecode words
// from a start PC over a non-pipelined Avalon-MM read master (at most one
// read outstanding) and buffers them, each tagged with its fetch address, in
// a DEPTH-entry FIFO. The sequencer pops the head entry. A redirect flushes
// the FIFO and restarts fetch at redirect_pc. If a read is still in flight
// when the redirect arrives, that read is completed and its data dropped.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   enable            allows new reads; never aborts a read already started
//   redirect          flush the queue and restart fetch at redirect_pc
//   redirect_pc       new fetch address
//   instr_ready       consumer pops the head entry when instr_valid is high
//   instr_valid       head entry present (registered)
//   instr_data        head instruction word
//   instr_pc          address the head word was fetched from
//   count             number of occupied entries
//   busy              read FSM is not IDLE
//   mem_address       Avalon address (held while mem_waitrequest is high)
//   mem_read          Avalon read strobe
//   mem_readdata      Avalon read data
//   mem_waitrequest   Avalon waitrequest
//-----------------------------------------------------------------------------
module lua_instr_prefetch_queue #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int PC_STEP = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         redirect,
   input  logic [ADDR_W-1:0]            redirect_pc,
   input  logic                         instr_ready,
   output logic                         instr_valid,
   output logic [DATA_W-1:0]            instr_data,
   output logic [ADDR_W-1:0]            instr_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         busy,
   output logic [ADDR_W-1:0]            mem_address,
   output logic                         mem_read,
   input  logic [DATA_W-1:0]            mem_readdata,
   input  logic                         mem_waitrequest
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

   // IDLE: no read on the bus. READ: fetching a word that will be kept.
   // DRAIN: finishing a read whose data is stale after a redirect.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
   logic [PTR_W-1:0]    head_q,   head_d;
   logic [PTR_W-1:0]    tail_q,   tail_d;
   logic [CNT_W-1:0]    count_q,  count_d;
   logic                instr_valid_q, instr_valid_d;

   logic [DATA_W-1:0]   data_mem_q [DEPTH];
   logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];

   logic                accept;
   logic                push;
   logic                pop;
   logic                issue;
   logic [CNT_W-1:0]    count_next;
   logic [ADDR_W-1:0]   drain_tgt;

   //--------------------------------------------------------------------------
   // Handshake terms
   //--------------------------------------------------------------------------
   assign mem_read    = (state_q == READ) || (state_q == DRAIN);
   assign mem_address = req_addr_q;
   assign accept      = mem_read & ~mem_waitrequest;

   // Only an accept in READ carries a word worth keeping; a redirect in the
   // same cycle makes that word stale.
   assign push = accept & (state_q == READ) & ~redirect;
   assign pop  = instr_ready & instr_valid_q & ~redirect;

   assign count_next = count_q + {{(CNT_W-1){1'b0}}, push}
                               - {{(CNT_W-1){1'b0}}, pop};

   // A new read is only started when its word is guaranteed a free slot,
   // so the FIFO can never overflow.
   assign issue = enable & ~redirect & (count_next < DEPTH_C);

   // In DRAIN the latest redirect target wins, including one arriving in
   // the accept cycle itself.
   assign drain_tgt = redirect ? redirect_pc : nxt_addr_q;

   //--------------------------------------------------------------------------
   // Next-state logic
   //--------------------------------------------------------------------------
   // NOTE: every variable assigned below gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      // NOTE: combinational logic uses blocking '='; the registers below use
      // non-blocking '<=' so all flops update together from old values.
      state_d    = state_q;
      req_addr_d = req_addr_q;
      nxt_addr_d = nxt_addr_q;

      unique case (state_q)
         IDLE: begin
            if (redirect) begin
               req_addr_d = redirect_pc;
               if (enable) begin
                  nxt_addr_d = redirect_pc + STEP_C;
                  state_d    = READ;
               end else begin
                  // Not fetching yet: the first issue must request redirect_pc.
                  nxt_addr_d = redirect_pc;
               end
            end else if (issue) begin
               req_addr_d = nxt_addr_q;
               nxt_addr_d = nxt_addr_q + STEP_C;
               state_d    = READ;
            end
         end

         READ: begin
            if (accept) begin
               if (redirect) begin
                  // Bus is free this edge, so restart directly without DRAIN.
                  req_addr_d = redirect_pc;
                  if (enable) begin
                     nxt_addr_d = redirect_pc + STEP_C;
                     state_d    = READ;
                  end else begin
                     nxt_addr_d = redirect_pc;
                     state_d    = IDLE;
                  end
               end else if (issue) begin
                  // Back-to-back: next address goes out with no idle cycle.
                  req_addr_d = nxt_addr_q;
                  nxt_addr_d = nxt_addr_q + STEP_C;
               end else begin
                  state_d = IDLE;
               end
            end else if (redirect) begin
               // Avalon forbids changing the address mid-read; remember the
               // target and let the stale read finish.
               nxt_addr_d = redirect_pc;
               state_d    = DRAIN;
            end
         end

         DRAIN: begin
            if (accept) begin
               req_addr_d = drain_tgt;
               if (enable) begin
                  nxt_addr_d = drain_tgt + STEP_C;
                  state_d    = READ;
               end else begin
                  // Keep the target as the next request so it is not skipped.
                  nxt_addr_d = drain_tgt;
                  state_d    = IDLE;
               end
            end else if (redirect) begin
               nxt_addr_d = redirect_pc;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // FIFO bookkeeping
   //--------------------------------------------------------------------------
   always_comb begin
      count_d       = count_next;
      head_d        = head_q;
      tail_d        = tail_q;

      if (push) begin
         tail_d = tail_q + 1'b1;
      end

      if (redirect) begin
         // Flush: everything between head and tail is discarded.
         count_d = '0;
         head_d  = tail_q;
      end else if (pop) begin
         head_d = head_q + 1'b1;
      end

      instr_valid_d = (count_d != '0);
   end

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         req_addr_q    <= '0;
         nxt_addr_q    <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_addr_q    <= req_addr_d;
         nxt_addr_q    <= nxt_addr_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, so clearing it would cost logic for nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[tail_q] <= mem_readdata;
         pc_mem_q[tail_q]   <= req_addr_q;
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   assign instr_valid = instr_valid_q;
   assign instr_data  = data_mem_q[head_q];
   assign instr_pc    = pc_mem_q[head_q];
   assign count       = count_q;
   assign busy        = (state_q != IDLE);

endmodule
